// File: rtl/u2_to_onehot_encoder_pkg.sv
// Shared definitions for the binary-to-one-hot streaming encoder.
// State encoding matches the pipeline-register FSM so both can share debug decoders.
package u2_to_onehot_encoder_pkg;

    typedef logic [1:0] state_t;

    localparam state_t S_EMPTY = 2'b00;
    localparam state_t S_ONE   = 2'b01;
    localparam state_t S_FULL  = 2'b11;

    // Only the three named codes are legal; 2'b10 is recovered to S_EMPTY.
    function automatic logic state_is_legal(input state_t s);
        return (s == S_EMPTY) || (s == S_ONE) || (s == S_FULL);
    endfunction

endpackage

// File: rtl/u2_to_onehot_encoder_comb.sv
// Purely combinational encoder: code v -> bit v of a 2*LEN one-hot vector,
// with err raised (and the vector all-zero) when v >= 2*LEN.
module u2_to_onehot_comb #(
    parameter int WIDTH = 4,
    parameter int LEN   = 8
) (
    input  logic [WIDTH-1:0]   code,
    output logic [2*LEN-1:0]   onehot,
    output logic               err
);

    // 2*LEN fits in WIDTH+1 bits because 2*LEN <= 2**WIDTH is enforced below.
    localparam logic [WIDTH:0] LIMIT = (WIDTH + 1)'(2 * LEN);

    generate
        if (2 * LEN > (1 << WIDTH)) begin : g_bad_params
            $error("u2_to_onehot_comb: 2*LEN must not exceed 2**WIDTH");
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < 2 * LEN; gi++) begin : g_bit
            assign onehot[gi] = (code == WIDTH'(gi));
        end
    endgenerate

    assign err = ({1'b0, code} >= LIMIT);

endmodule

// File: rtl/u2_to_onehot_encoder.sv
// Streaming binary-to-one-hot encoder with READY/VALID on both sides and a
// two-entry skid buffer (main register drives the outputs, skid absorbs one stall).
module u2_to_onehot_encoder
    import u2_to_onehot_encoder_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN   = 8
) (
    input  logic             i_CLK,
    input  logic             i_RSTn,
    input  logic             i_VALID,
    output logic             o_READY,
    input  logic [WIDTH-1:0] i_D,
    output logic             o_VALID,
    input  logic             i_READY,
    output logic [LEN-1:0]   o_a_oh,
    output logic [LEN-1:0]   o_b_oh,
    output logic             o_err
);

    localparam int WORD_W = 2 * LEN + 1;

    logic [2*LEN-1:0]  enc_oh;
    logic              enc_err;
    logic [WORD_W-1:0] enc_word;

    state_t            state_reg, state_next;
    logic [WORD_W-1:0] main_reg, main_next;
    logic [WORD_W-1:0] skid_reg, skid_next;

    logic accept;
    logic emit;

    u2_to_onehot_comb #(
        .WIDTH (WIDTH),
        .LEN   (LEN)
    ) u_comb (
        .code   (i_D),
        .onehot (enc_oh),
        .err    (enc_err)
    );

    // Stored word layout: {err, b_half, a_half}.
    assign enc_word = {enc_err, enc_oh};

    // Handshake outputs depend on state only, never on the other side's signals.
    assign o_READY = (state_reg == S_EMPTY) || (state_reg == S_ONE);
    assign o_VALID = (state_reg == S_ONE)   || (state_reg == S_FULL);

    assign accept = i_VALID & o_READY;
    assign emit   = o_VALID & i_READY;

    always_comb begin
        state_next = state_reg;
        main_next  = main_reg;
        skid_next  = skid_reg;
        if (!state_is_legal(state_reg)) begin
            state_next = S_EMPTY;
        end else begin
            case (state_reg)
                S_EMPTY: begin
                    if (accept) begin
                        main_next  = enc_word;
                        state_next = S_ONE;
                    end
                end
                S_ONE: begin
                    if (accept && emit) begin
                        main_next  = enc_word;
                    end else if (accept) begin
                        skid_next  = enc_word;
                        state_next = S_FULL;
                    end else if (emit) begin
                        state_next = S_EMPTY;
                    end
                end
                S_FULL: begin
                    if (emit) begin
                        main_next  = skid_reg;
                        state_next = S_ONE;
                    end
                end
                default: begin
                    state_next = S_EMPTY;
                end
            endcase
        end
    end

    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_reg <= S_EMPTY;
            main_reg  <= '0;
            skid_reg  <= '0;
        end else begin
            state_reg <= state_next;
            main_reg  <= main_next;
            skid_reg  <= skid_next;
        end
    end

    assign o_a_oh = main_reg[LEN-1:0];
    assign o_b_oh = main_reg[2*LEN-1:LEN];
    assign o_err  = main_reg[2*LEN];

endmodule

// File: tb/tb_u2_to_onehot_encoder.sv
// Directed bench for the one-hot encoder: an 8-bit-half instance for the main
// handshake/ordering cases and a 6-bit-half instance for the out-of-range code.
module tb_u2_to_onehot_encoder;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    logic       v8, r8;
    logic [3:0] d8;
    logic       o_ready8, o_valid8, e8;
    logic [7:0] a8, b8;

    logic       v6, r6;
    logic [3:0] d6;
    logic       o_ready6, o_valid6, e6;
    logic [5:0] a6, b6;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    u2_to_onehot_encoder #(.WIDTH(4), .LEN(8)) dut8 (
        .i_CLK   (clk),
        .i_RSTn  (rst_n),
        .i_VALID (v8),
        .o_READY (o_ready8),
        .i_D     (d8),
        .o_VALID (o_valid8),
        .i_READY (r8),
        .o_a_oh  (a8),
        .o_b_oh  (b8),
        .o_err   (e8)
    );

    u2_to_onehot_encoder #(.WIDTH(4), .LEN(6)) dut6 (
        .i_CLK   (clk),
        .i_RSTn  (rst_n),
        .i_VALID (v6),
        .o_READY (o_ready6),
        .i_D     (d6),
        .o_VALID (o_valid6),
        .i_READY (r6),
        .o_a_oh  (a6),
        .o_b_oh  (b6),
        .o_err   (e6)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [15:0] exp16;
        v8 = 1'b0; r8 = 1'b0; d8 = '0;
        v6 = 1'b0; r6 = 1'b0; d6 = '0;

        // Power-on reset state
        #12;
        chk("rst_valid", 32'(o_valid8), 32'd0);
        chk("rst_ready", 32'(o_ready8), 32'd1);
        chk("rst_halves", 32'({b8, a8}), 32'h0);
        chk("rst_err", 32'(e8), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        $display("step: reset released");

        // Single word d=3
        r8 = 1'b1; d8 = 4'd3; v8 = 1'b1;
        step();
        v8 = 1'b0;
        chk("d3_valid", 32'(o_valid8), 32'd1);
        chk("d3_a", 32'(a8), 32'h08);
        chk("d3_b", 32'(b8), 32'h00);
        chk("d3_err", 32'(e8), 32'd0);
        step();
        chk("d3_drained", 32'(o_valid8), 32'd0);
        $display("step: d=3 -> a=%h b=%h", a8, b8);

        // Single word d=12 lands in the high half
        d8 = 4'd12; v8 = 1'b1;
        step();
        v8 = 1'b0;
        chk("d12_a", 32'(a8), 32'h00);
        chk("d12_b", 32'(b8), 32'h10);
        chk("d12_err", 32'(e8), 32'd0);
        step();
        $display("step: d=12 -> a=%h b=%h", a8, b8);

        // Back-pressure: 5 then 9 with i_READY low fills the skid buffer
        r8 = 1'b0; d8 = 4'd5; v8 = 1'b1;
        step();
        chk("bp_ready_one", 32'(o_ready8), 32'd1);
        chk("bp_first_a", 32'(a8), 32'h20);
        d8 = 4'd9;
        step();
        chk("bp_ready_full", 32'(o_ready8), 32'd0);
        chk("bp_valid_full", 32'(o_valid8), 32'd1);
        chk("bp_hold_a", 32'(a8), 32'h20);
        // Word offered while full must be ignored
        d8 = 4'd7;
        step();
        chk("bp_hold2_a", 32'(a8), 32'h20);
        chk("bp_hold2_b", 32'(b8), 32'h00);
        chk("bp_hold2_ready", 32'(o_ready8), 32'd0);
        r8 = 1'b1;
        step();
        v8 = 1'b0;
        chk("bp_second_a", 32'(a8), 32'h00);
        chk("bp_second_b", 32'(b8), 32'h02);
        chk("bp_ready_again", 32'(o_ready8), 32'd1);
        step();
        chk("bp_drained", 32'(o_valid8), 32'd0);
        $display("step: back-pressure 5,9 emitted in order");

        // LEN=6 instance: 12 is out of range, 11 is the top bit
        r6 = 1'b1; d6 = 4'd12; v6 = 1'b1;
        step();
        d6 = 4'd11;
        chk("len6_err", 32'(e6), 32'd1);
        chk("len6_err_halves", 32'({b6, a6}), 32'h0);
        chk("len6_err_valid", 32'(o_valid6), 32'd1);
        step();
        v6 = 1'b0;
        chk("len6_11_b", 32'(b6), 32'h20);
        chk("len6_11_a", 32'(a6), 32'h00);
        chk("len6_11_err", 32'(e6), 32'd0);
        step();
        chk("len6_drained", 32'(o_valid6), 32'd0);
        $display("step: LEN=6 out-of-range and top-bit codes");

        // Full-rate stream 0..15
        r8 = 1'b1; v8 = 1'b1;
        for (int i = 0; i < 16; i++) begin
            d8 = 4'(i);
            step();
            exp16 = 16'h1 << i;
            chk($sformatf("stream_%0d_word", i), 32'({b8, a8}), 32'(exp16));
            chk($sformatf("stream_%0d_valid", i), 32'(o_valid8), 32'd1);
            chk($sformatf("stream_%0d_err", i), 32'(e8), 32'd0);
            $display("stream: d=%0d -> b=%h a=%h", i, b8, a8);
        end
        v8 = 1'b0;
        step();
        chk("stream_drained", 32'(o_valid8), 32'd0);

        // Asynchronous reset while the buffer is full
        r8 = 1'b0; v8 = 1'b1; d8 = 4'd1;
        step();
        d8 = 4'd2;
        step();
        v8 = 1'b0;
        chk("midrst_full", 32'(o_ready8), 32'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("midrst_valid", 32'(o_valid8), 32'd0);
        chk("midrst_ready", 32'(o_ready8), 32'd1);
        chk("midrst_halves", 32'({b8, a8}), 32'h0);
        chk("midrst_err", 32'(e8), 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        r8 = 1'b1;
        step();
        chk("midrst_discarded", 32'(o_valid8), 32'd0);
        $display("step: async reset mid-FULL discarded buffered words");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
